// File: rtl/text_display_pkg.sv
// Shared types and constants for the text display scheduler.
package text_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    localparam int unsigned TEXT_DWELL_DEFAULT = 2000;
    localparam int unsigned TEXT_GAP_DEFAULT   = 100;

    // Counter width large enough to hold the longer of the two intervals.
    function automatic int unsigned timer_width(input int unsigned dwell, input int unsigned gap);
        return $clog2(((dwell > gap) ? dwell : gap) + 1);
    endfunction

endpackage

// File: rtl/text_dwell_timer.sv
// Generic loadable down-counter; terminal count when it reaches zero. Never wraps.
module text_dwell_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/text_display_scheduler.sv
// Round-robin owner of the shared text display with fixed dwell and blank gap.
// Define TEXT_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module text_display_scheduler
    import text_display_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MSG_W        = 4,
    parameter int unsigned DWELL_CYCLES = TEXT_DWELL_DEFAULT,
    parameter int unsigned GAP_CYCLES   = TEXT_GAP_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic                     show,
    output logic [MSG_W-1:0]         msg_id,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = timer_width(DWELL_CYCLES, GAP_CYCLES);
    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = (GAP_CYCLES == 0) ? '0 : TMR_W'(GAP_CYCLES - 1);

    sched_state_e     state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [MSG_W-1:0] msg_arr [NUM_REQ];

    logic [PTR_W:0]   pick_c;
    logic             pick_found_c;
    logic [PTR_W-1:0] pick_idx_c;
    logic             tmr_load_c;
    logic [TMR_W-1:0] tmr_val_c;
    logic             tmr_tc_c;
    logic             show_end_c;

    // First set request at or after ptr, wrapping around.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   ptr);
        logic [PTR_W:0] res;
        logic [31:0]    idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % NUM_REQ;
            if (r[PTR_W'(idx)]) res = {1'b1, PTR_W'(idx)};
        end
        return res;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
        assign msg_arr[g] = req_msg[g*MSG_W +: MSG_W];
    end

    // Arbitration and timer load on every state entry.
    always_comb begin
        pick_c       = rr_pick(req, rr_ptr);
        pick_found_c = pick_c[PTR_W];
        pick_idx_c   = pick_c[PTR_W-1:0];
        show_end_c   = tmr_tc_c || !req[owner];
        tmr_load_c   = 1'b0;
        tmr_val_c    = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = DWELL_LOAD;
                end
            end
            ST_SHOW: begin
                if (show_end_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_tc_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = '0;
                end
            end
            default: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = '0;
            end
        endcase
    end

    text_dwell_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load_c),
        .load_val(tmr_val_c),
        .tc_c    (tmr_tc_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            show   <= 1'b0;
            msg_id <= '0;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found_c) begin
                        state  <= ST_SHOW;
                        owner  <= pick_idx_c;
                        grant  <= NUM_REQ'(1) << pick_idx_c;
                        msg_id <= msg_arr[pick_idx_c];
                        show   <= 1'b1;
                        busy   <= 1'b1;
`ifdef TEXT_SCHED_FIXED_PRIO_EN
                        rr_ptr <= '0;
`else
                        rr_ptr <= PTR_W'((32'(pick_idx_c) + 32'd1) % NUM_REQ);
`endif
                    end
                end
                ST_SHOW: begin
                    // Expiry wins over a simultaneous drop, so done still pulses.
                    if (show_end_c) begin
                        show   <= 1'b0;
                        grant  <= '0;
                        msg_id <= '0;
                        done   <= tmr_tc_c ? grant : '0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_tc_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    show  <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_display_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/dones, a negedge monitor checks them.
module tb_text_display_scheduler;

    localparam int unsigned NR  = 4;
    localparam int unsigned MW  = 4;
    localparam int unsigned DW  = 5;
    localparam int unsigned GP  = 2;

    typedef struct {
        logic [NR-1:0] grant;
        logic [MW-1:0] msg;
        int            len;
    } gexp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*MW-1:0] req_msg = 16'h9527;
    logic            show;
    logic [MW-1:0]   msg_id;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    gexp_t         gq[$];
    logic [NR-1:0] dq[$];

    text_display_scheduler #(
        .NUM_REQ(NR), .MSG_W(MW), .DWELL_CYCLES(DW), .GAP_CYCLES(GP)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
        .show(show), .msg_id(msg_id), .grant(grant), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [NR-1:0] g, input logic [MW-1:0] m, input int len);
        gexp_t e;
        e.grant = g;
        e.msg   = m;
        e.len   = len;
        gq.push_back(e);
    endtask

    task automatic wait_done(output logic [NR-1:0] d);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        d = '0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (done != '0) begin
                got = 1'b1;
                d = done;
            end
        end
        chk("done_seen", {31'b0, got}, 1);
    endtask

    task automatic drop_on_done();
        logic [NR-1:0] d;
        wait_done(d);
        req = req & ~d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'b0, busy}, 0);
    endtask

    // Monitor: grant/msg/show length/gap length/done against the queues.
    initial begin : monitor
        gexp_t cur;
        int run_len, gap_cnt;
        logic prev_show, prev_busy;
        logic [NR-1:0] prev_done;
        cur.grant = '0; cur.msg = '0; cur.len = 0;
        run_len = 0; gap_cnt = 0;
        prev_show = 1'b0; prev_busy = 1'b0; prev_done = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (show && !prev_show) begin
                    chk("grant_expected", {31'b0, gq.size() != 0}, 1);
                    if (gq.size() != 0) cur = gq.pop_front();
                    run_len = 0;
                end
                if (show) begin
                    run_len++;
                    chk("grant", 32'(grant), 32'(cur.grant));
                    chk("msg_id", 32'(msg_id), 32'(cur.msg));
                end
                if (!show && prev_show) begin
                    if (cur.len != 0) chk("show_len", run_len, cur.len);
                    chk("grant_clear", 32'(grant), 0);
                    chk("msg_clear", 32'(msg_id), 0);
                    gap_cnt = 0;
                end
                if (busy && !show) gap_cnt++;
                if (!busy && prev_busy && !prev_show) chk("gap_len", gap_cnt, GP);
                if (done != '0) begin
                    chk("done_expected", {31'b0, dq.size() != 0}, 1);
                    if (dq.size() != 0) chk("done", 32'(done), 32'(dq.pop_front()));
                    chk("done_after_show", {30'b0, prev_show, show}, 32'b10);
                    chk("done_one_cycle", 32'(prev_done), 0);
                end
                prev_show = show;
                prev_busy = busy;
                prev_done = done;
            end
        end
    end

    initial begin : stim
        tick();
        tick();
        chk("rst_show", {31'b0, show}, 0);
        chk("rst_msg", 32'(msg_id), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        tick();
        mon_en = 1'b1;

        // Single request with 1-cycle latency.
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
        req = 4'b0001;
        tick();
        chk("s1_show", {31'b0, show}, 1);
        chk("s1_msg", 32'(msg_id), 32'h7);
        chk("s1_grant", 32'(grant), 32'b0001);
        drop_on_done();
        chk("s1_busy_gap", {31'b0, busy}, 1);
        wait_idle();

        // Pointer has advanced past requester 0.
`ifdef TEXT_SCHED_FIXED_PRIO_EN
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
`else
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
`endif
        req = 4'b0011;
        drop_on_done();
        drop_on_done();
        wait_idle();

        // Round robin from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
        push_g(4'b1000, 4'h9, DW); dq.push_back(4'b1000);
        req = 4'b1011;
        drop_on_done();
        drop_on_done();
        drop_on_done();
        wait_idle();

        // Abandon in the 3rd show cycle.
        push_g(4'b0100, 4'h5, 3);
        req = 4'b0100;
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk("s3_show_off", {31'b0, show}, 0);
        chk("s3_no_done", 32'(done), 0);
        chk("s3_busy", {31'b0, busy}, 1);
        wait_idle();

        // Drop coincident with expiry still completes.
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
        req = 4'b0010;
        tick();
        repeat (4) tick();
        req = 4'b0000;
        tick();
        chk("s4_done", 32'(done), 32'b0010);
        wait_idle();

        // Reset in show cycle 2, then all request.
        push_g(4'b0100, 4'h5, 0);
        req = 4'b0100;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("s5_show", {31'b0, show}, 0);
        chk("s5_msg", 32'(msg_id), 0);
        chk("s5_grant", 32'(grant), 0);
        chk("s5_done", 32'(done), 0);
        chk("s5_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
        req = 4'b1111;
        tick();
        chk("s5_grant_after_reset", 32'(grant), 32'b0001);
        begin
            logic [NR-1:0] d;
            wait_done(d);
        end
        req = 4'b0000;
        wait_idle();

        // Message ID frozen while shown.
        push_g(4'b0001, 4'h7, DW); dq.push_back(4'b0001);
        req = 4'b0001;
        tick();
        req_msg = 16'h9523;
        drop_on_done();
        wait_idle();
        req_msg = 16'h9527;

        // Held requests keep rotating (or stay on requester 1 with fixed priority).
`ifdef TEXT_SCHED_FIXED_PRIO_EN
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
`else
        push_g(4'b0010, 4'h2, DW); dq.push_back(4'b0010);
        push_g(4'b1000, 4'h9, DW); dq.push_back(4'b1000);
`endif
        req = 4'b1010;
        begin
            logic [NR-1:0] d;
            wait_done(d);
            wait_done(d);
        end
        req = 4'b0000;
        wait_idle();
        tick();
        tick();

        chk("grant_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/text_display_scheduler.md
Name: text_display_scheduler

Overview:
- Shares the single on-screen text display among NUM_REQ requesters (game events, score, prompts) using round-robin arbitration.
- Latches the winner's message ID and holds it on the display for a fixed dwell time, then forces a blank gap before the next message.
- Uses an internal dwell/gap timer and replaces the ad-hoc enable/endTime counters that requesters currently run themselves.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MSG_W, 4, message ID width
- DWELL_CYCLES, 2000, cycles a message stays visible (>=1)
- GAP_CYCLES, 100, blank cycles between messages (0 = no gap)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per requester; held until done or abandoned
- req_msg  in  NUM_REQ*MSG_W  message ID per requester; slice i = bits [i*MSG_W +: MSG_W]
- show  out  1  display enable; high while a message is visible
- msg_id  out  MSG_W  message currently shown; 0 when show=0
- grant  out  NUM_REQ  one-hot owner of the display; all 0 when idle or in gap
- done  out  NUM_REQ  one-cycle pulse to the owner when its dwell completes normally
- busy  out  1  high in SHOW or GAP

Behaviour:
- Reset: synchronous, checked every posedge; overrides everything.
  - show, msg_id, grant, done, busy = 0; state = IDLE; rr_ptr = 0; timer = 0.
- States: IDLE, SHOW, GAP (2-bit encoding).
- IDLE:
  - If req != 0, pick the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: state = SHOW, grant = one-hot winner, msg_id = req_msg slice latched at grant, show = 1, busy = 1.
  - Latency from req to show is 1 cycle.
  - rr_ptr = winner+1 mod NUM_REQ, updated at grant.
- SHOW:
  - show is high for exactly DWELL_CYCLES cycles; timer counts 0..DWELL_CYCLES-1.
  - msg_id stays frozen even if req_msg changes.
  - After the last show cycle: done[winner] = 1 for one cycle; show, grant and msg_id clear; state = GAP.
  - If GAP_CYCLES = 0, state = IDLE instead.
- Abandon: if req[winner] drops while in SHOW, the next cycle clears show and grant, asserts no done, and enters GAP (or IDLE if GAP_CYCLES = 0).
- GAP:
  - show = 0 and busy = 1 for exactly GAP_CYCLES cycles, then IDLE.
  - Requests are ignored (not latched) during GAP.
- Simultaneous events:
  - Dwell expiry and req drop in the same cycle count as a normal completion; done is pulsed.
  - A requester that keeps req high after done is re-eligible in IDLE and is arbitrated normally. It is not favoured, because rr_ptr has already advanced.
- Timer width: $clog2(max(DWELL_CYCLES, GAP_CYCLES)+1); resets to 0 on every state entry; never wraps.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TEXT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed or held at 0.
- Undefined (default): round-robin as described above.

Decomposition:
- Package text_display_pkg holds:
  - state enum typedef (IDLE/SHOW/GAP)
  - default constants TEXT_DWELL_DEFAULT = 2000 and TEXT_GAP_DEFAULT = 100
  - localparam function for timer width
- Sub-module text_dwell_timer: load/clear input, terminal-count output; generic down-counter reused for both SHOW and GAP.
- Arbiter stays inline; it is a small function.

Test Plan (DWELL_CYCLES=5, GAP_CYCLES=2, NUM_REQ=4, MSG_W=4):
- Single request: req=0001, req_msg[0]=0x7 → show=1, msg_id=7, grant=0001 one cycle later. Show holds 5 cycles, then done=0001 for 1 cycle, busy stays high 2 more cycles, then idle.
- Round-robin: req=1011 held, each requester drops req on its done → grant order 0001, 0010, 1000. Never two grants at once.
- Abandon: req[2] drops in the 3rd show cycle → show=0 next cycle, done stays 0000, GAP 2 cycles, then idle.
- Expiry coincident with drop: req[1] drops in the 5th show cycle → done=0010 pulses.
- Reset mid-SHOW: assert reset in show cycle 2 → next edge all outputs 0. The next grant after reset goes to requester 0 when req=1111.
- Frozen msg: req_msg[0] changes 7→3 during SHOW → msg_id stays 7. Rerun with TEXT_SCHED_FIXED_PRIO_EN defined and req=1010 held → requester 1 is always granted.
